// File: rtl/safecrack_autodialer.sv
// safecrack_autodialer: drives the safecrack lock's buttons and program switch.
// Programs a code (start_prog) or brute-forces all 64 codes (start_search).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start_prog, prog_code[5:0] program request and code ([5:4] first digit)
//   start_search               brute-force search request
//   abort                      cancel any operation, back to IDLE
//   led_green, led_red         lock LEDs (asynchronous, synchronised here)
//   btn_n[3:0], prog_sw        button and switch drive to the lock
//   busy, done                 operation in progress / one-cycle completion
//   found, found_code[5:0]     search result
//   exhausted                  search tried all 64 codes without success
//   attempt_cnt[6:0]           codes fully entered in the current search
module safecrack_autodialer #(
   parameter int PRESS_CYCLES     = 8,
   parameter int GAP_CYCLES       = 8,
   parameter int RESP_WAIT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_prog,
   input  logic [5:0] prog_code,
   input  logic       start_search,
   input  logic       abort,
   input  logic       led_green,
   input  logic       led_red,
   output logic [3:0] btn_n,
   output logic       prog_sw,
   output logic       busy,
   output logic       done,
   output logic       found,
   output logic [5:0] found_code,
   output logic       exhausted,
   output logic [6:0] attempt_cnt
);

   localparam int MAX_PG = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
   localparam int MAX_C  = (MAX_PG > RESP_WAIT_CYCLES) ? MAX_PG : RESP_WAIT_CYCLES;
   localparam int CW     = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] PRESS_LD = CW'(PRESS_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] RESP_LD  = CW'(RESP_WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, SW_ON, PRESS, GAP, SW_OFF, WAIT_RESP, WAIT_LOCK, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    digit_q, digit_d;
   logic [5:0]    cand_q, cand_d;
   logic [5:0]    code_q, code_d;
   logic          mode_q, mode_d;
   logic          wl_gap_q, wl_gap_d;
   logic [3:0]    btn_n_q, btn_n_d;
   logic          prog_sw_q, prog_sw_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          found_q, found_d;
   logic [5:0]    found_code_q, found_code_d;
   logic          exhausted_q, exhausted_d;
   logic [6:0]    attempt_cnt_q, attempt_cnt_d;
   logic          gs1_q, gs1_d, gs2_q, gs2_d;
   logic          rs1_q, rs1_d, rs2_q, rs2_d;

   logic [5:0]    act_code;
   logic          advance;
   logic          cnt_zero;

   // Button pattern for one digit: bit k low sends digit value k.
   function automatic logic [3:0] digit_btn(input logic [5:0] code,
                                            input logic [1:0] idx);
      logic [1:0] k;
      unique case (idx)
         2'd0:    k = code[5:4];
         2'd1:    k = code[3:2];
         default: k = code[1:0];
      endcase
      return ~(4'b0001 << k);
   endfunction

   // mode_q: 1 = search (candidate register), 0 = program (latched code)
   assign act_code = mode_q ? cand_q : code_q;
   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      digit_d       = digit_q;
      cand_d        = cand_q;
      code_d        = code_q;
      mode_d        = mode_q;
      wl_gap_d      = wl_gap_q;
      btn_n_d       = btn_n_q;
      prog_sw_d     = prog_sw_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      found_d       = found_q;
      found_code_d  = found_code_q;
      exhausted_d   = exhausted_q;
      attempt_cnt_d = attempt_cnt_q;
      gs1_d         = led_green;
      gs2_d         = gs1_q;
      rs1_d         = led_red;
      rs2_d         = rs1_q;
      advance       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_prog || start_search) begin
               busy_d        = 1'b1;
               digit_d       = 2'd0;
               found_d       = 1'b0;
               found_code_d  = 6'd0;
               exhausted_d   = 1'b0;
               attempt_cnt_d = 7'd0;
            end
            if (start_prog) begin
               mode_d    = 1'b0;
               code_d    = prog_code;
               prog_sw_d = 1'b1;
               cnt_d     = GAP_LD;
               state_d   = SW_ON;
            end else if (start_search) begin
               mode_d  = 1'b1;
               cand_d  = 6'd0;
               btn_n_d = digit_btn(6'd0, 2'd0);
               cnt_d   = PRESS_LD;
               state_d = PRESS;
            end
         end
         SW_ON: begin
            if (cnt_zero) begin
               digit_d = 2'd0;
               btn_n_d = digit_btn(act_code, 2'd0);
               cnt_d   = PRESS_LD;
               state_d = PRESS;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PRESS: begin
            if (cnt_zero) begin
               btn_n_d = 4'hF;
               cnt_d   = GAP_LD;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - 1'b1;
            end else if (digit_q != 2'd2) begin
               digit_d = digit_q + 2'd1;
               btn_n_d = digit_btn(act_code, digit_q + 2'd1);
               cnt_d   = PRESS_LD;
               state_d = PRESS;
            end else if (mode_q) begin
               attempt_cnt_d = attempt_cnt_q + 7'd1;
               cnt_d         = RESP_LD;
               state_d       = WAIT_RESP;
            end else begin
               prog_sw_d = 1'b0;
               cnt_d     = GAP_LD;
               state_d   = SW_OFF;
            end
         end
         SW_OFF: begin
            if (cnt_zero) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WAIT_RESP: begin
            if (gs2_q) begin
               found_d      = 1'b1;
               found_code_d = cand_q;
               done_d       = 1'b1;
               state_d      = DONE;
            end else if (rs2_q) begin
               wl_gap_d = 1'b0;
               state_d  = WAIT_LOCK;
            end else if (cnt_zero) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WAIT_LOCK: begin
            // Wait for red to clear (unbounded), then one settle gap.
            if (!wl_gap_q) begin
               if (!rs2_q) begin
                  wl_gap_d = 1'b1;
                  cnt_d    = GAP_LD;
               end
            end else if (cnt_zero) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (advance) begin
         if (cand_q == 6'd63) begin
            exhausted_d = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
         end else begin
            cand_d  = cand_q + 6'd1;
            digit_d = 2'd0;
            btn_n_d = digit_btn(cand_q + 6'd1, 2'd0);
            cnt_d   = PRESS_LD;
            state_d = PRESS;
         end
      end

      if (abort) begin
         state_d       = IDLE;
         btn_n_d       = 4'hF;
         prog_sw_d     = 1'b0;
         busy_d        = 1'b0;
         done_d        = 1'b0;
         found_d       = found_q;
         found_code_d  = found_code_q;
         exhausted_d   = exhausted_q;
         attempt_cnt_d = attempt_cnt_q;
         cand_d        = cand_q;
         code_d        = code_q;
         mode_d        = mode_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         digit_q       <= 2'd0;
         cand_q        <= 6'd0;
         code_q        <= 6'd0;
         mode_q        <= 1'b0;
         wl_gap_q      <= 1'b0;
         btn_n_q       <= 4'hF;
         prog_sw_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         found_code_q  <= 6'd0;
         exhausted_q   <= 1'b0;
         attempt_cnt_q <= 7'd0;
         gs1_q         <= 1'b0;
         gs2_q         <= 1'b0;
         rs1_q         <= 1'b0;
         rs2_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         digit_q       <= digit_d;
         cand_q        <= cand_d;
         code_q        <= code_d;
         mode_q        <= mode_d;
         wl_gap_q      <= wl_gap_d;
         btn_n_q       <= btn_n_d;
         prog_sw_q     <= prog_sw_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         found_q       <= found_d;
         found_code_q  <= found_code_d;
         exhausted_q   <= exhausted_d;
         attempt_cnt_q <= attempt_cnt_d;
         gs1_q         <= gs1_d;
         gs2_q         <= gs2_d;
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
      end
   end

   assign btn_n       = btn_n_q;
   assign prog_sw     = prog_sw_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign found       = found_q;
   assign found_code  = found_code_q;
   assign exhausted   = exhausted_q;
   assign attempt_cnt = attempt_cnt_q;

endmodule

// File: tb/tb_safecrack_autodialer.sv
// tb_safecrack_autodialer: directed bench for safecrack_autodialer.
// Includes a small behavioural lock model driving led_green / led_red.
module tb_safecrack_autodialer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_prog = 1'b0;
   logic [5:0] prog_code = 6'd0;
   logic       start_search = 1'b0;
   logic       abort = 1'b0;
   logic       led_green;
   logic       led_red;
   logic [3:0] btn_n;
   logic       prog_sw;
   logic       busy;
   logic       done;
   logic       found;
   logic [5:0] found_code;
   logic       exhausted;
   logic [6:0] attempt_cnt;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   safecrack_autodialer dut (
      .clk(clk), .rst_n(rst_n),
      .start_prog(start_prog), .prog_code(prog_code),
      .start_search(start_search), .abort(abort),
      .led_green(led_green), .led_red(led_red),
      .btn_n(btn_n), .prog_sw(prog_sw),
      .busy(busy), .done(done),
      .found(found), .found_code(found_code),
      .exhausted(exhausted), .attempt_cnt(attempt_cnt)
   );

   // Lock model: 3 digits on button falling edges, green on match,
   // red for m_lock_len cycles after every third error.
   logic       m_clr = 1'b0;
   logic [5:0] m_code = 6'd0;
   int         m_lock_len = 0;
   logic       m_can_unlock = 1'b1;
   logic [3:0] m_prev = 4'hF;
   logic [5:0] m_entry = 6'd0;
   int         m_ndig = 0;
   int         m_err = 0;
   int         m_red = 0;
   logic       m_green = 1'b0;
   int         m_red_eps = 0;

   assign led_green = m_green;
   assign led_red   = (m_red != 0);

   always @(posedge clk) begin
      m_prev <= btn_n;
      if (m_red > 0) m_red <= m_red - 1;
      if (m_clr) begin
         m_ndig <= 0; m_err <= 0; m_red <= 0;
         m_green <= 1'b0; m_red_eps <= 0;
      end else if (m_red == 0 && !prog_sw) begin
         for (int k = 0; k < 4; k++) begin
            if (m_prev[k] && !btn_n[k]) begin
               if (m_ndig == 2) begin
                  m_ndig <= 0;
                  if ({m_entry[5:2], 2'(k)} == m_code && m_can_unlock)
                     m_green <= 1'b1;
                  else if (m_lock_len > 0 && m_err == 2) begin
                     m_err <= 0;
                     m_red <= m_lock_len;
                     m_red_eps <= m_red_eps + 1;
                  end else
                     m_err <= m_err + 1;
               end else begin
                  m_ndig <= m_ndig + 1;
                  if (m_ndig == 0) m_entry[5:4] <= 2'(k);
                  else m_entry[3:2] <= 2'(k);
               end
            end
         end
      end
   end

   task automatic setup_model(input logic [5:0] code, input int lock_len,
                              input logic can_unlock);
      @(negedge clk);
      m_code = code; m_lock_len = lock_len; m_can_unlock = can_unlock;
      m_clr = 1'b1;
      @(negedge clk);
      m_clr = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Waits at negedges until done; cyc counts cycles from the caller's point.
   task automatic wait_done(input int limit, output int cyc, output bit ok);
      ok = 1'b0; cyc = 0;
      while (cyc < limit && !ok) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      vectors++;
      if ({btn_n, prog_sw, busy, done, found, found_code, exhausted, attempt_cnt}
          !== {4'hF, 4'b0000, 6'd0, 1'b0, 7'd0}) begin
         miscompares++;
         $display("FAIL reset: btn_n=%h sw=%b busy=%b done=%b found=%b fc=%0d ex=%b att=%0d, required F/0/0/0/0/0/0/0",
                  btn_n, prog_sw, busy, done, found, found_code, exhausted, attempt_cnt);
      end
   endtask

   task automatic test_program;
      logic [3:0] dig_btn [3];
      logic [3:0] e_btn;
      logic e_sw, e_busy, e_done;
      int errs;
      dig_btn = '{4'b1011, 4'b1101, 4'b0111};
      errs = 0;
      @(negedge clk);
      prog_code = 6'b10_01_11; start_prog = 1'b1;
      @(negedge clk);
      start_prog = 1'b0;
      for (int c = 0; c < 70; c++) begin
         e_btn = 4'hF; e_sw = 1'b0;
         e_busy = (c < 65); e_done = (c == 64);
         if (c < 56) e_sw = 1'b1;
         if (c >= 8 && c < 56 && ((c - 8) % 16) < 8) e_btn = dig_btn[(c - 8) / 16];
         vectors++;
         if ({btn_n, prog_sw, busy, done} !== {e_btn, e_sw, e_busy, e_done}) begin
            miscompares++;
            if (errs < 5)
               $display("FAIL program c=%0d: btn_n=%h sw=%b busy=%b done=%b, required %h %b %b %b",
                        c, btn_n, prog_sw, busy, done, e_btn, e_sw, e_busy, e_done);
            errs++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_dual_start;
      int cyc; bit ok;
      @(negedge clk);
      prog_code = 6'd0; start_prog = 1'b1; start_search = 1'b1;
      @(negedge clk);
      start_prog = 1'b0; start_search = 1'b0;
      vectors++;
      if ({prog_sw, btn_n, busy} !== {1'b1, 4'hF, 1'b1}) begin
         miscompares++;
         $display("FAIL dual_start: sw=%b btn_n=%h busy=%b, required 1 F 1", prog_sw, btn_n, busy);
      end
      wait_done(200, cyc, ok);
      vectors++;
      if (!ok || cyc != 64 || found !== 1'b0 || attempt_cnt !== 7'd0) begin
         miscompares++;
         $display("FAIL dual_done: ok=%b cyc=%0d found=%b att=%0d, required 1 64 0 0",
                  ok, cyc, found, attempt_cnt);
      end
      repeat (2) @(negedge clk);
      abort = 1'b1; start_search = 1'b1;
      @(negedge clk);
      abort = 1'b0; start_search = 1'b0;
      vectors++;
      if ({busy, btn_n} !== {1'b0, 4'hF}) begin
         miscompares++;
         $display("FAIL abort_vs_start: busy=%b btn_n=%h, required 0 F", busy, btn_n);
      end
   endtask

   task automatic test_search_found;
      int cyc; bit ok; int errs;
      setup_model(6'b00_00_10, 0, 1'b1);
      start_search = 1'b1;
      @(negedge clk);
      start_search = 1'b0;
      vectors++;
      if ({btn_n, busy, prog_sw} !== {4'b1110, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL search_first: btn_n=%h busy=%b sw=%b, required E 1 0", btn_n, busy, prog_sw);
      end
      wait_done(400, cyc, ok);
      vectors++;
      if (!ok || cyc != 177) begin
         miscompares++;
         $display("FAIL search_latency: ok=%b cyc=%0d, required 1 177", ok, cyc);
      end
      vectors++;
      if ({found, found_code, attempt_cnt, exhausted} !== {1'b1, 6'd2, 7'd3, 1'b0}) begin
         miscompares++;
         $display("FAIL search_result: found=%b fc=%0d att=%0d ex=%b, required 1 2 3 0",
                  found, found_code, attempt_cnt, exhausted);
      end
      @(negedge clk);
      vectors++;
      if ({done, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL search_end: done=%b busy=%b, required 0 0", done, busy);
      end
      errs = 0;
      repeat (20) begin
         @(negedge clk);
         if (btn_n !== 4'hF || found !== 1'b1) errs++;
      end
      vectors++;
      if (errs != 0) begin
         miscompares++;
         $display("FAIL search_after: %0d bad cycles, required 0", errs);
      end
   endtask

   task automatic test_abort;
      int cyc; bit ok; int errs;
      setup_model(6'b00_00_10, 0, 1'b1);
      start_search = 1'b1;
      @(negedge clk);
      start_search = 1'b0;
      repeat (84) @(negedge clk);
      vectors++;
      if (btn_n !== 4'b1110) begin
         miscompares++;
         $display("FAIL abort_pre: btn_n=%h, required E", btn_n);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if ({btn_n, busy, done} !== {4'hF, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL abort_now: btn_n=%h busy=%b done=%b, required F 0 0", btn_n, busy, done);
      end
      errs = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0 || btn_n !== 4'hF || busy !== 1'b0) errs++;
      end
      vectors++;
      if (errs != 0) begin
         miscompares++;
         $display("FAIL abort_quiet: %0d bad cycles, required 0", errs);
      end
      setup_model(6'b00_00_10, 0, 1'b1);
      start_search = 1'b1;
      @(negedge clk);
      start_search = 1'b0;
      vectors++;
      if ({attempt_cnt, btn_n} !== {7'd0, 4'b1110}) begin
         miscompares++;
         $display("FAIL restart: att=%0d btn_n=%h, required 0 E", attempt_cnt, btn_n);
      end
      wait_done(400, cyc, ok);
      vectors++;
      if (!ok || cyc != 177 || found_code !== 6'd2 || attempt_cnt !== 7'd3) begin
         miscompares++;
         $display("FAIL restart_done: ok=%b cyc=%0d fc=%0d att=%0d, required 1 177 2 3",
                  ok, cyc, found_code, attempt_cnt);
      end
   endtask

   task automatic test_lockout;
      int cyc; bit ok;
      setup_model(6'b11_11_11, 100, 1'b1);
      start_search = 1'b1;
      @(negedge clk);
      start_search = 1'b0;
      wait_done(20000, cyc, ok);
      vectors++;
      if (!ok || found !== 1'b1 || found_code !== 6'd63 || attempt_cnt !== 7'd64) begin
         miscompares++;
         $display("FAIL lockout: ok=%b found=%b fc=%0d att=%0d, required 1 1 63 64",
                  ok, found, found_code, attempt_cnt);
      end
      vectors++;
      if (m_red_eps != 21) begin
         miscompares++;
         $display("FAIL lockout_eps: %0d red episodes, required 21", m_red_eps);
      end
   endtask

   task automatic test_exhausted;
      int cyc; bit ok;
      setup_model(6'b01_01_01, 0, 1'b0);
      start_search = 1'b1;
      @(negedge clk);
      start_search = 1'b0;
      wait_done(6000, cyc, ok);
      vectors++;
      if (!ok || cyc != 4096) begin
         miscompares++;
         $display("FAIL exhaust_latency: ok=%b cyc=%0d, required 1 4096", ok, cyc);
      end
      vectors++;
      if ({exhausted, found, attempt_cnt} !== {1'b1, 1'b0, 7'd64}) begin
         miscompares++;
         $display("FAIL exhaust_result: ex=%b found=%b att=%0d, required 1 0 64",
                  exhausted, found, attempt_cnt);
      end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      prog_code = 6'b10_01_11; start_prog = 1'b1;
      @(negedge clk);
      start_prog = 1'b0;
      repeat (10) @(negedge clk);
      vectors++;
      if ({btn_n, prog_sw} !== {4'b1011, 1'b1}) begin
         miscompares++;
         $display("FAIL areset_pre: btn_n=%h sw=%b, required B 1", btn_n, prog_sw);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({btn_n, prog_sw, busy, done, found, found_code, exhausted, attempt_cnt}
          !== {4'hF, 4'b0000, 6'd0, 1'b0, 7'd0}) begin
         miscompares++;
         $display("FAIL areset: btn_n=%h sw=%b busy=%b done=%b found=%b fc=%0d ex=%b att=%0d, required F/0/0/0/0/0/0/0",
                  btn_n, prog_sw, busy, done, found, found_code, exhausted, attempt_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_program();
      test_dual_start();
      test_search_found();
      test_abort();
      test_lockout();
      test_exhausted();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
